// File: rtl/alu_result_skid.sv
// alu_result_skid
//   Registered output stage for the bitwise ALU units. Each result is captured
//   under a valid/ready handshake, tagged with zero/negative flags, and held in a
//   two-entry skid buffer (head + skid). in_ready decodes registered state only,
//   so a stalled consumer never forms a ready-to-ready path back into the ALU.
//   A counter tracks the number of results handed to the consumer.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_y is the ALU result
//   out_valid/out_ready   : downstream handshake
//   out_y, out_zero,
//   out_neg               : head entry and its stored flags
//   res_count             : completed output handshakes, modulo 2^CNT_W
module alu_result_skid #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] res_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head_y, skid_y;
  logic             head_zero, head_neg, skid_zero, skid_neg;
  logic             accept, deliver;
  logic             head_load_in, head_load_skid, skid_load;

  function automatic logic flag_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  function automatic logic flag_neg(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction

  assign in_ready  = (state != FULL) & ~rst;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  assign out_y    = head_y;
  assign out_zero = head_zero;
  assign out_neg  = head_neg;

  always_comb begin
    state_nxt      = state;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          head_load_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          head_load_in = 1'b1;
        end else if (accept) begin
          // Head is still owed to the consumer; park the new result.
          skid_load = 1'b1;
          state_nxt = FULL;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          head_load_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_y    <= '0;
      head_zero <= 1'b0;
      head_neg  <= 1'b0;
      skid_y    <= '0;
      skid_zero <= 1'b0;
      skid_neg  <= 1'b0;
      res_count <= '0;
    end else begin
      state <= state_nxt;
      // Flags are computed once at write time and travel with the entry.
      if (head_load_in) begin
        head_y    <= in_y;
        head_zero <= flag_zero(in_y);
        head_neg  <= flag_neg(in_y);
      end else if (head_load_skid) begin
        head_y    <= skid_y;
        head_zero <= skid_zero;
        head_neg  <= skid_neg;
      end
      if (skid_load) begin
        skid_y    <= in_y;
        skid_zero <= flag_zero(in_y);
        skid_neg  <= flag_neg(in_y);
      end
      if (deliver) begin
        res_count <= res_count + 1'b1;
      end
    end
  end

endmodule
